// File: rtl/pipe_start_fsm_gen.sv
// Start-up sequencer for a fixed-depth pipeline: clear, reset, pause, fill, run.
// Optional triplicated state/counters/outputs with majority vote and per-cycle scrubbing.
module pipe_start_fsm_gen #(
    parameter int unsigned DEPTH_W   = 9,
    parameter int unsigned CLR_CYC   = 6,
    parameter int unsigned RST_CYC   = 5,
    parameter int unsigned PAUSE_CYC = 5,
    parameter int unsigned TMR       = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RESTART,
    input  logic [DEPTH_W-1:0] PDEPTH,
    output logic               PIP_RST,
    output logic               WE,
    output logic               RE,
    output logic               READY,
    output logic [2:0]         STATE,
    output logic               TMR_ERR
);

    localparam int unsigned NC    = (TMR != 0) ? 3 : 1;
    localparam int unsigned HLD_W = 8;
    localparam int unsigned OUT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RESET = 3'd2,
        S_PAUSE = 3'd3,
        S_FILL  = 3'd4,
        S_RUN   = 3'd5
    } state_t;

    logic [NC-1:0][2:0]         state_q;
    logic [NC-1:0][HLD_W-1:0]   hold_q;
    logic [NC-1:0][DEPTH_W-1:0] fill_q;
    logic [NC-1:0][DEPTH_W-1:0] depth_q;
    logic [NC-1:0][OUT_W-1:0]   out_q;
    logic                       tmr_err_q;

    logic [2:0]         state_v;
    logic [HLD_W-1:0]   hold_v;
    logic [DEPTH_W-1:0] fill_v;
    logic [DEPTH_W-1:0] depth_v;
    logic [OUT_W-1:0]   out_v;
    logic               mismatch_c;

    state_t             state_d;
    logic [HLD_W-1:0]   hold_d;
    logic [DEPTH_W-1:0] fill_d;
    logic [DEPTH_W-1:0] depth_d;
    logic [OUT_W-1:0]   out_d;

    // Bitwise majority of the copies; a single copy passes straight through
    generate
        if (NC == 3) begin : g_vote
            assign state_v = (state_q[0] & state_q[1]) | (state_q[0] & state_q[2]) | (state_q[1] & state_q[2]);
            assign hold_v  = (hold_q[0]  & hold_q[1])  | (hold_q[0]  & hold_q[2])  | (hold_q[1]  & hold_q[2]);
            assign fill_v  = (fill_q[0]  & fill_q[1])  | (fill_q[0]  & fill_q[2])  | (fill_q[1]  & fill_q[2]);
            assign depth_v = (depth_q[0] & depth_q[1]) | (depth_q[0] & depth_q[2]) | (depth_q[1] & depth_q[2]);
            assign out_v   = (out_q[0]   & out_q[1])   | (out_q[0]   & out_q[2])   | (out_q[1]   & out_q[2]);
            assign mismatch_c = (state_q[0] != state_v) || (state_q[1] != state_v) || (state_q[2] != state_v) ||
                                (hold_q[0]  != hold_v)  || (hold_q[1]  != hold_v)  || (hold_q[2]  != hold_v)  ||
                                (fill_q[0]  != fill_v)  || (fill_q[1]  != fill_v)  || (fill_q[2]  != fill_v);
        end else begin : g_single
            assign state_v    = state_q[0];
            assign hold_v     = hold_q[0];
            assign fill_v     = fill_q[0];
            assign depth_v    = depth_q[0];
            assign out_v      = out_q[0];
            assign mismatch_c = 1'b0;
        end
    endgenerate

    // Next state, counters and decoded outputs, all computed from the voted values
    always_comb begin
        state_d = S_IDLE;
        hold_d  = '0;
        fill_d  = '0;
        depth_d = depth_v;
        out_d   = '0;

        case (state_v)
            S_IDLE:  state_d = RESTART ? S_IDLE : S_CLEAR;
            S_CLEAR: begin
                if (RESTART)                               state_d = S_IDLE;
                else if (hold_v == HLD_W'(CLR_CYC - 1))    state_d = S_RESET;
                else                                       state_d = S_CLEAR;
            end
            S_RESET: begin
                if (RESTART)                               state_d = S_IDLE;
                else if (hold_v == HLD_W'(RST_CYC - 1))    state_d = S_PAUSE;
                else                                       state_d = S_RESET;
            end
            S_PAUSE: begin
                if (RESTART)                               state_d = S_IDLE;
                else if (hold_v == HLD_W'(PAUSE_CYC - 1))  state_d = (depth_v != '0) ? S_FILL : S_RUN;
                else                                       state_d = S_PAUSE;
            end
            S_FILL: begin
                if (RESTART)                               state_d = S_IDLE;
                else if (fill_v == depth_v)                state_d = S_RUN;
                else                                       state_d = S_FILL;
            end
            S_RUN:   state_d = RESTART ? S_IDLE : S_RUN;
            default: state_d = S_IDLE;
        endcase

        // Hold counter runs only while staying in a timed phase, so it cannot wrap
        if ((3'(state_d) == state_v) &&
            (state_v == S_CLEAR || state_v == S_RESET || state_v == S_PAUSE)) begin
            hold_d = hold_v + HLD_W'(1);
        end

        if (state_d == S_FILL) begin
            fill_d = (state_v == S_FILL) ? fill_v + DEPTH_W'(1) : DEPTH_W'(1);
        end

        if (state_d == S_PAUSE && state_v != S_PAUSE) begin
            depth_d = PDEPTH;
        end

        out_d = {state_d == S_RESET,
                 state_d == S_FILL || state_d == S_RUN,
                 state_d == S_RUN,
                 state_d == S_RUN};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= '0;
            hold_q    <= '0;
            fill_q    <= '0;
            depth_q   <= '0;
            out_q     <= '0;
            tmr_err_q <= 1'b0;
        end else begin
            state_q   <= {NC{3'(state_d)}};
            hold_q    <= {NC{hold_d}};
            fill_q    <= {NC{fill_d}};
            depth_q   <= {NC{depth_d}};
            out_q     <= {NC{out_d}};
            tmr_err_q <= mismatch_c;
        end
    end

    assign {PIP_RST, WE, RE, READY} = out_v;
    assign STATE   = state_v;
    assign TMR_ERR = tmr_err_q;

endmodule

// File: tb/tb_pipe_start_fsm_gen.sv
// Directed bench for pipe_start_fsm_gen: checkpoint table per scenario plus corner sequences.
module tb_pipe_start_fsm_gen;

    localparam int unsigned DW = 9;

    localparam logic [6:0] O_IDLE  = 7'b000_0000;
    localparam logic [6:0] O_CLEAR = 7'b001_0000;
    localparam logic [6:0] O_RESET = 7'b010_1000;
    localparam logic [6:0] O_PAUSE = 7'b011_0000;
    localparam logic [6:0] O_FILL  = 7'b100_0100;
    localparam logic [6:0] O_RUN   = 7'b101_0111;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RESTART = 1'b0;
    logic [DW-1:0] PDEPTH = '0;
    logic          PIP_RST, WE, RE, READY, TMR_ERR;
    logic [2:0]    STATE;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sc;
        int         n;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    pipe_start_fsm_gen dut (
        .CLK     (CLK),
        .RST     (RST),
        .RESTART (RESTART),
        .PDEPTH  (PDEPTH),
        .PIP_RST (PIP_RST),
        .WE      (WE),
        .RE      (RE),
        .READY   (READY),
        .STATE   (STATE),
        .TMR_ERR (TMR_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] obs();
        return {STATE, PIP_RST, WE, RE, READY};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Hold reset, then release at a falling edge so the next rising edge is n=1
    task automatic do_reset(input logic [DW-1:0] d);
        RST     = 1'b1;
        RESTART = 1'b0;
        PDEPTH  = d;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic inject_state_copy2();
        logic [8:0] sv;
        sv    = dut.state_q;
        sv[6] = ~sv[6];
        force dut.state_q = sv;
        #1;
        release dut.state_q;
        #1;
        chk("seu_injected", 32'(sv[8:6]), 32'(dut.state_q[2]));
        chk("seu_vote_masks", 32'(obs()), 32'(O_PAUSE));
    endtask

    task automatic run_table(input int sc, input int last, input int inj_n,
                             output int pip_n, output int fill_n, output int err_n);
        pip_n  = 0;
        fill_n = 0;
        err_n  = 0;
        for (int n = 1; n <= last; n++) begin
            step();
            if (PIP_RST) pip_n++;
            if (STATE == 3'd4) fill_n++;
            if (TMR_ERR) err_n++;
            foreach (tbl[i]) begin
                if (tbl[i].sc == sc && tbl[i].n == n)
                    chk($sformatf("sc%0d_n%0d", sc, n), 32'(obs()), 32'(tbl[i].exp));
            end
            if (n == inj_n + 1) begin
                chk("seu_err_pulse", 32'(TMR_ERR), 32'd1);
                chk("seu_scrubbed", 32'(dut.state_q[2]), 32'd3);
            end
            if (n == inj_n) inject_state_copy2();
        end
    endtask

    initial begin
        int pip_n, fill_n, err_n, k;

        // Scenario 0: PDEPTH=20; scenario 1: PDEPTH=0
        tbl.push_back('{0, 1,  O_CLEAR});
        tbl.push_back('{0, 6,  O_CLEAR});
        tbl.push_back('{0, 7,  O_RESET});
        tbl.push_back('{0, 11, O_RESET});
        tbl.push_back('{0, 12, O_PAUSE});
        tbl.push_back('{0, 16, O_PAUSE});
        tbl.push_back('{0, 17, O_FILL});
        tbl.push_back('{0, 36, O_FILL});
        tbl.push_back('{0, 37, O_RUN});
        tbl.push_back('{0, 40, O_RUN});
        tbl.push_back('{1, 16, O_PAUSE});
        tbl.push_back('{1, 17, O_RUN});

        #3;
        chk("reset_outputs", 32'(obs()), 32'(O_IDLE));
        chk("reset_tmr_err", 32'(TMR_ERR), 32'd0);

        do_reset(DW'(20));
        run_table(0, 42, -5, pip_n, fill_n, err_n);
        chk("sc0_pip_cycles", 32'(pip_n), 32'd5);
        chk("sc0_fill_cycles", 32'(fill_n), 32'd20);
        chk("sc0_no_tmr_err", 32'(err_n), 32'd0);

        // Restart pulse from RUN
        RESTART = 1'b1;
        step();
        chk("run_restart_idle", 32'(obs()), 32'(O_IDLE));
        RESTART = 1'b0;
        for (k = 1; k <= 7; k++) begin
            step();
            if (k == 6) chk("rerun_clear_last", 32'(obs()), 32'(O_CLEAR));
            if (k == 7) chk("rerun_pip_rst", 32'(obs()), 32'(O_RESET));
        end

        // RESTART held: aborts RESET_PIPE and stays in IDLE
        RESTART = 1'b1;
        step();
        chk("abort_reset_pipe", 32'(obs()), 32'(O_IDLE));
        repeat (5) step();
        chk("restart_held_idle", 32'(obs()), 32'(O_IDLE));
        RESTART = 1'b0;

        do_reset(DW'(0));
        run_table(1, 20, -5, pip_n, fill_n, err_n);
        chk("sc1_no_fill", 32'(fill_n), 32'd0);

        // Abort in FILL after 5 writes, replay with depth 3
        do_reset(DW'(20));
        repeat (21) step();
        chk("fill_5th_write", 32'(obs()), 32'(O_FILL));
        PDEPTH  = DW'(3);
        RESTART = 1'b1;
        step();
        chk("fill_abort_idle", 32'(obs()), 32'(O_IDLE));
        RESTART = 1'b0;
        fill_n  = 0;
        for (k = 1; k <= 30; k++) begin
            step();
            if (STATE == 3'd4) fill_n++;
            if (k == 17) chk("replay_fill_start", 32'(obs()), 32'(O_FILL));
            if (k == 20) chk("replay_run", 32'(obs()), 32'(O_RUN));
        end
        chk("replay_fill_cycles", 32'(fill_n), 32'd3);

        // SEU in state copy 2 during PAUSE
        do_reset(DW'(20));
        run_table(0, 42, 13, pip_n, fill_n, err_n);
        chk("seu_pip_cycles", 32'(pip_n), 32'd5);
        chk("seu_fill_cycles", 32'(fill_n), 32'd20);
        chk("seu_err_count", 32'(err_n), 32'd1);

        // Asynchronous reset mid RESET_PIPE
        do_reset(DW'(20));
        repeat (9) step();
        chk("mid_pip_rst_high", 32'(PIP_RST), 32'd1);
        RST = 1'b1;
        #1;
        chk("async_rst_outputs", 32'(obs()), 32'(O_IDLE));
        do_reset(DW'(20));
        run_table(0, 42, -5, pip_n, fill_n, err_n);
        chk("post_rst_pip_cycles", 32'(pip_n), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
